// File: rtl/gray_tracker_pkg.sv
// Shared state encodings and error-counter constants for the Gray position tracker.
package gray_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/gray_stab_filter.sv
// Two-flop synchroniser on the raw encoder lines plus a stability counter that
// flags a candidate code once it has been seen STABLE_CYCLES times in a row.
module gray_stab_filter #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] cand,
    output logic         stable
);

    localparam int             SW       = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYCLES - 1);

    logic [N-1:0]  s1, s2, cand_r;
    logic [SW-1:0] stab;

    // cand/stable leave through one more register so the pair is always a
    // consistent snapshot; this stage sets the end-to-end accept latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            cand_r <= '0;
            stab   <= '0;
            cand   <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
            if (s2 != cand_r) begin
                cand_r <= s2;
                stab   <= '0;
            end else if (stab < STAB_MAX) begin
                stab <= stab + 1'b1;
            end
            cand   <= cand_r;
            stable <= (s2 == cand_r) && (stab == STAB_MAX);
        end
    end

endmodule

// File: rtl/gray_position_tracker.sv
// Absolute Gray encoder front end: filtered code acceptance, single-bit step
// check, Gray-to-binary decode, step direction and multi-turn counting.
module gray_position_tracker
    import gray_tracker_pkg::*;
#(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TURN_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic [N-1:0]         gray_in,
    output logic [N-1:0]         pos_bin,
    output logic [TURN_W-1:0]    turns,
    output logic                 pos_valid,
    output logic                 dir,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [N-1:0] POS_MAX = '1;

    state_t                 state_q, state_d;
    logic [N-1:0]           cand, cand_bin, acc, acc_d, pos_d, pos_inc, diff;
    logic [TURN_W-1:0]      turns_d;
    logic [ERR_CNT_W-1:0]   cnt_d;
    logic                   stable, pv_d, dir_d, err_d, single;

    gray_stab_filter #(.N(N), .STABLE_CYCLES(STABLE_CYCLES)) u_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .gray_in (gray_in),
        .cand    (cand),
        .stable  (stable)
    );

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        cand_bin = '0;
        for (int i = 0; i < N; i++) cand_bin[i] = ^(cand >> i);
    end

    assign diff    = cand ^ acc;
    assign single  = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
    assign pos_inc = pos_bin + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc;
        pos_d   = pos_bin;
        turns_d = turns;
        dir_d   = dir;
        err_d   = step_err;
        cnt_d   = err_cnt;
        pv_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_INIT;
            ST_INIT: begin
                if (!en) state_d = ST_IDLE;
                else if (stable) begin
                    acc_d   = cand;
                    pos_d   = cand_bin;
                    pv_d    = 1'b1;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!en) state_d = ST_IDLE;
                else if (stable && (cand != acc)) begin
                    acc_d = cand;
                    pos_d = cand_bin;
                    pv_d  = 1'b1;
                    if (single) begin
                        dir_d = (cand_bin == pos_inc);
                        if (pos_bin == POS_MAX && cand_bin == '0)      turns_d = turns + 1'b1;
                        else if (pos_bin == '0 && cand_bin == POS_MAX) turns_d = turns - 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt != ERR_CNT_MAX) cnt_d = err_cnt + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // clear overrides any accept decided above; INIT picks the code up again
        if (clear) begin
            acc_d   = acc;
            pos_d   = pos_bin;
            dir_d   = dir;
            pv_d    = 1'b0;
            turns_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = en ? ST_INIT : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc       <= '0;
            pos_bin   <= '0;
            turns     <= '0;
            dir       <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
            pos_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc       <= acc_d;
            pos_bin   <= pos_d;
            turns     <= turns_d;
            dir       <= dir_d;
            step_err  <= err_d;
            err_cnt   <= cnt_d;
            pos_valid <= pv_d;
        end
    end

endmodule

// File: tb/tb_gray_position_tracker.sv
// Directed bench for gray_position_tracker (N=4, STABLE_CYCLES=4, TURN_W=8).
module tb_gray_position_tracker;

    logic       clk, rst_n, en, clear;
    logic [3:0] gray_in, pos_bin;
    logic [7:0] turns, err_cnt;
    logic       pos_valid, dir, step_err;
    int         vecs = 0;
    int         errs = 0;
    int         lat, npv;

    gray_position_tracker #(.N(4), .STABLE_CYCLES(4), .TURN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clear     (clear),
        .gray_in   (gray_in),
        .pos_bin   (pos_bin),
        .turns     (turns),
        .pos_valid (pos_valid),
        .dir       (dir),
        .step_err  (step_err),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a code at a negedge and watch 20 edges; lat = edge index of first pos_valid.
    task automatic apply_code(input logic [3:0] g, output int l, output int n);
        @(negedge clk);
        gray_in = g;
        l = -1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pos_valid) begin
                n++;
                if (l < 0) l = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; gray_in = 4'b0110;
        repeat (3) tick();
        vecs++;
        if ({pos_bin, turns, err_cnt} !== 20'h0) begin
            errs++;
            $display("FAIL reset_vec: pos=%0d turns=%0d err_cnt=%0d, expected all 0", pos_bin, turns, err_cnt);
        end
        vecs++;
        if ({pos_valid, dir, step_err} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags: pv/dir/serr=%b%b%b, expected 000", pos_valid, dir, step_err);
        end
    endtask

    // Release with en=1 and code 0110 waiting: first edge captures it into s1.
    task automatic test_init_latency();
        int l, n;
        @(negedge clk);
        en = 1'b1;
        rst_n = 1'b1;
        l = -1; n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pos_valid) begin
                n++;
                if (l < 0) l = i;
            end
        end
        vecs++;
        if (l !== 8 || n !== 1) begin
            errs++;
            $display("FAIL init_latency: first pv at edge %0d count %0d, expected edge 8 count 1", l, n);
        end
        vecs++;
        if (pos_bin !== 4'd4 || turns !== 8'd0 || step_err !== 1'b0) begin
            errs++;
            $display("FAIL init_value: pos=%0d turns=%0d serr=%b, expected 4 0 0", pos_bin, turns, step_err);
        end
    endtask

    task automatic test_up_wrap();
        for (int p = 5; p <= 15; p++) begin
            apply_code(4'(p ^ (p >> 1)), lat, npv);
            vecs++;
            if (lat !== 8 || npv !== 1 || pos_bin !== 4'(p) || dir !== 1'b1 || step_err !== 1'b0) begin
                errs++;
                $display("FAIL up_step p=%0d: lat=%0d npv=%0d pos=%0d dir=%b serr=%b, expected lat=8 npv=1 pos=%0d dir=1 serr=0",
                         p, lat, npv, pos_bin, dir, step_err, p);
            end
        end
        apply_code(4'b0000, lat, npv);
        vecs++;
        if (lat !== 8 || npv !== 1 || pos_bin !== 4'd0 || dir !== 1'b1 || turns !== 8'd1) begin
            errs++;
            $display("FAIL wrap_up: lat=%0d npv=%0d pos=%0d dir=%b turns=%0d, expected 8 1 0 1 1", lat, npv, pos_bin, dir, turns);
        end
        apply_code(4'b1000, lat, npv);
        vecs++;
        if (lat !== 8 || npv !== 1 || pos_bin !== 4'd15 || dir !== 1'b0 || turns !== 8'd0) begin
            errs++;
            $display("FAIL wrap_down: lat=%0d npv=%0d pos=%0d dir=%b turns=%0d, expected 8 1 15 0 0", lat, npv, pos_bin, dir, turns);
        end
    endtask

    task automatic test_glitch();
        int n = 0;
        @(negedge clk);
        gray_in = 4'b1001;
        repeat (2) tick();
        @(negedge clk);
        gray_in = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pos_valid) n++;
        end
        vecs++;
        if (n !== 0 || pos_bin !== 4'd15 || turns !== 8'd0 || dir !== 1'b0) begin
            errs++;
            $display("FAIL glitch: npv=%0d pos=%0d turns=%0d dir=%b, expected 0 15 0 0", n, pos_bin, turns, dir);
        end
    endtask

    task automatic test_jump();
        int miss = 0;
        apply_code(4'b0000, lat, npv);
        vecs++;
        if (pos_bin !== 4'd0 || turns !== 8'd1 || err_cnt !== 8'd0) begin
            errs++;
            $display("FAIL pre_jump: pos=%0d turns=%0d err_cnt=%0d, expected 0 1 0", pos_bin, turns, err_cnt);
        end
        apply_code(4'b0011, lat, npv);
        vecs++;
        if (lat !== 8 || npv !== 1 || pos_bin !== 4'd2 || step_err !== 1'b1 || err_cnt !== 8'd1 || turns !== 8'd1 || dir !== 1'b1) begin
            errs++;
            $display("FAIL jump: lat=%0d npv=%0d pos=%0d serr=%b err_cnt=%0d turns=%0d dir=%b, expected 8 1 2 1 1 1 1",
                     lat, npv, pos_bin, step_err, err_cnt, turns, dir);
        end
        for (int k = 0; k < 300; k++) begin
            apply_code((k % 2 == 1) ? 4'b0011 : 4'b0000, lat, npv);
            if (lat !== 8 || npv !== 1) miss++;
        end
        vecs++;
        if (miss !== 0 || err_cnt !== 8'd255 || step_err !== 1'b1 || turns !== 8'd1) begin
            errs++;
            $display("FAIL err_saturate: missed=%0d err_cnt=%0d serr=%b turns=%0d, expected 0 255 1 1", miss, err_cnt, step_err, turns);
        end
    endtask

    // Code 0010 accepted on edge 8 after the drive; clear is sampled on that same edge.
    task automatic test_clear();
        @(negedge clk);
        gray_in = 4'b0010;
        repeat (7) tick();
        @(negedge clk);
        clear = 1'b1;
        tick();
        vecs++;
        if (pos_valid !== 1'b0 || pos_bin !== 4'd2 || turns !== 8'd0 || err_cnt !== 8'd0 || step_err !== 1'b0) begin
            errs++;
            $display("FAIL clear_edge: pv=%b pos=%0d turns=%0d err_cnt=%0d serr=%b, expected 0 2 0 0 0",
                     pos_valid, pos_bin, turns, err_cnt, step_err);
        end
        @(negedge clk);
        clear = 1'b0;
        tick();
        vecs++;
        if (pos_valid !== 1'b1 || pos_bin !== 4'd3 || turns !== 8'd0 || step_err !== 1'b0) begin
            errs++;
            $display("FAIL clear_reinit: pv=%b pos=%0d turns=%0d serr=%b, expected 1 3 0 0", pos_valid, pos_bin, turns, step_err);
        end
        tick();
        vecs++;
        if (pos_valid !== 1'b0) begin
            errs++;
            $display("FAIL clear_pulse_width: pv=%b, expected 0", pos_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        @(negedge clk);
        gray_in = 4'b0110;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({pos_bin, turns, err_cnt, pos_valid, dir, step_err} !== 23'h0) begin
            errs++;
            $display("FAIL reset_mid: pos=%0d turns=%0d err_cnt=%0d pv=%b dir=%b serr=%b, expected all 0",
                     pos_bin, turns, err_cnt, pos_valid, dir, step_err);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pos_valid) n++;
        end
        vecs++;
        if (n !== 0 || pos_bin !== 4'd0 || turns !== 8'd0) begin
            errs++;
            $display("FAIL idle_after_reset: npv=%0d pos=%0d turns=%0d, expected 0 0 0", n, pos_bin, turns);
        end
    endtask

    initial begin
        test_reset();
        test_init_latency();
        test_up_wrap();
        test_glitch();
        test_jump();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
